// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush/bubble control with multi-cycle EXE tracking
// Optional stall/flush statistics counters enabled by HAZARD_CONTROLLER_STATS_EN.
module hazard_controller #(
    parameter int MC_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mc_op,
    input  logic        mem_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        mc_done,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MC_LATENCY - 2);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] next_cnt;
    logic       load_use;
    logic       busy;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // While reset is held the outputs are those of RUN, so an in-flight op never reports done.
    assign busy = rst && (state == MC_BUSY);

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        mc_done      = 1'b0;
        next_state   = state;
        next_cnt     = cnt;
        if (mem_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b1;
            next_state   = RUN;
        end else if (busy) begin
            if (cnt != 4'd0) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                next_cnt     = cnt - 4'd1;
            end else begin
                mc_done    = 1'b1;
                next_state = RUN;
            end
        end else if (ex_mc_op) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            next_state   = MC_BUSY;
            next_cnt     = CNT_INIT;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

`ifdef HAZARD_CONTROLLER_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (!pc_write && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
            if (mem_branch_taken && (flush_q != 16'hFFFF))
                flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 16'd0;
    assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller (MC_LATENCY=4)
module tb_hazard_controller;

`ifdef HAZARD_CONTROLLER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, idex_flush, mc_done}
    localparam logic [7:0] O_NONE = 8'b1110_0000;
    localparam logic [7:0] O_LU   = 8'b0011_0000;
    localparam logic [7:0] O_MC   = 8'b0000_1000;
    localparam logic [7:0] O_DONE = 8'b1110_0001;
    localparam logic [7:0] O_BR   = 8'b1110_1110;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ex_mc_op, mem_branch_taken;
    logic        pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble;
    logic        ifid_flush, idex_flush, mc_done;
    logic [15:0] stall_cycles, flush_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q[$];
    int          stall_m  = 0;
    int          flush_m  = 0;

    hazard_controller #(.MC_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_mc_op(ex_mc_op),
        .mem_branch_taken(mem_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mc_done(mc_done),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one cycle at negedge, compare outputs mid-cycle, then advance the counter model.
    task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mrd, input logic [4:0] ert,
                        input logic mc, input logic br, input logic [7:0] exp);
        logic [7:0] e;
        @(negedge clk);
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mrd; ex_rt = ert; ex_mc_op = mc; mem_branch_taken = br;
        exp_q.push_back(exp);
        #2;
        e = exp_q.pop_front();
        check(tag, {24'd0, pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
                    ifid_flush, idex_flush, mc_done}, {24'd0, e});
        if (!r) begin
            stall_m = 0;
            flush_m = 0;
        end else begin
            if (!e[7] && stall_m < 65535) stall_m++;
            if (br && flush_m < 65535) flush_m++;
        end
    endtask

    task automatic check_counters(input string tag);
        @(negedge clk);
        check({tag, "_stall"}, {16'd0, stall_cycles}, STATS ? stall_m : 0);
        check({tag, "_flush"}, {16'd0, flush_count},  STATS ? flush_m : 0);
    endtask

    initial begin
        rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = '0; ex_mc_op = 1'b0; mem_branch_taken = 1'b0;

        step("rst_idle",     0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        step("rst_idle2",    0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        check_counters("reset");
        step("none",         1, 3, 4, 1, 0, 0, 0, 0, O_NONE);

        step("lu_rs",        1, 5, 0, 0, 1, 5, 0, 0, O_LU);
        step("lu_after",     1, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        step("lu_rt",        1, 1, 7, 1, 1, 7, 0, 0, O_LU);
        step("lu_rt_unused", 1, 1, 7, 0, 1, 7, 0, 0, O_NONE);
        step("lu_r0",        1, 0, 0, 1, 1, 0, 0, 0, O_NONE);
        step("no_load",      1, 5, 5, 1, 0, 5, 0, 0, O_NONE);

        step("mc_start",     1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("mc_busy1",     1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("mc_busy2",     1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("mc_done",      1, 0, 0, 0, 0, 0, 1, 0, O_DONE);
        step("mc_restart",   1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("mc2_busy1",    1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("mc2_busy2",    1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("mc2_done",     1, 0, 0, 0, 0, 0, 0, 0, O_DONE);
        step("mc2_after",    1, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        check_counters("after_mc");

        step("br_mc_start",  1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("br_mc_busy1",  1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("br_in_busy2",  1, 0, 0, 0, 0, 0, 1, 1, O_BR);
        step("br_to_run",    1, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        step("br_lu",        1, 5, 0, 0, 1, 5, 0, 1, O_BR);
        step("br_plain",     1, 0, 0, 0, 0, 0, 0, 1, O_BR);
        check_counters("after_br");

        step("rmc_start",    1, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("rmc_rst",      0, 0, 0, 0, 0, 0, 1, 0, O_MC);
        step("rmc_after",    1, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        step("rmc_after2",   1, 0, 0, 0, 0, 0, 0, 0, O_NONE);

        step("sat_start",    1, 9, 0, 0, 1, 9, 0, 1, O_BR);
        @(negedge clk);
        mem_branch_taken = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (stall_m < 65535) stall_m++;
        end
        check_counters("saturate");
        step("sat_hold",     1, 9, 0, 0, 1, 9, 0, 0, O_LU);
        check_counters("sat_hold");
        step("stats_rst",    0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        check_counters("stats_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
